// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store sequencer. It turns the EX/MEM pipeline register
// contents into one request on a simple request/grant data bus, stalls the
// front of the pipeline until the bus access completes, and returns the
// sign- or zero-extended load result.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   memWrite_MEM      : store request
//   resultSrc_MEM     : 2'b01 marks a load (a store takes priority)
//   funct3_MEM        : access size / signedness (RISC-V encoding)
//   ALUResult_MEM     : byte address
//   storeOut_MEM      : store data, low-aligned
//   dmem_req/we       : registered bus request and write flag
//   dmem_addr         : word-aligned bus address
//   dmem_wstrb/wdata  : byte enables and lane-replicated write data
//   dmem_gnt          : bus accepted the request this cycle
//   dmem_rvalid/rdata : read data return
//   stall_MEM         : hold IF..MEM while an access is in flight
//   readData_MEM      : extended load result, held until the next load
//   misalign_MEM      : misaligned access flag
//
// Configuration
//   MEM_ACCESS_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses
//   are flagged on misalign_MEM and suppressed. When undefined the flag is
//   tied low and the offending low address bits are simply ignored.
// -----------------------------------------------------------------------------
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWrite_MEM,
    input  logic [1:0]  resultSrc_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] storeOut_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEM,
    output logic [31:0] readData_MEM,
    output logic        misalign_MEM
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;

    logic        is_store;
    logic        is_load;
    logic        kind_ok;
    logic        misaligned;
    logic        launch;
    logic        capture;
    logic [1:0]  off;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] o);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << o;
            2'b01:   s = o[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Replicate the low byte/half across all lanes so the strobes pick it up.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Select the addressed byte/half from the returned word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign off      = ALUResult_MEM[1:0];
    assign is_store = memWrite_MEM;
    assign is_load  = !memWrite_MEM && (resultSrc_MEM == 2'b01);

    // Unsigned-load encodings exist only for loads; 011/110/111 are never valid.
    always_comb begin
        kind_ok = 1'b0;
        if (is_store) begin
            kind_ok = (funct3_MEM == 3'b000) || (funct3_MEM == 3'b001) || (funct3_MEM == 3'b010);
        end else if (is_load) begin
            kind_ok = (funct3_MEM == 3'b000) || (funct3_MEM == 3'b001) || (funct3_MEM == 3'b010) ||
                      (funct3_MEM == 3'b100) || (funct3_MEM == 3'b101);
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misaligned = kind_ok &&
                        (((funct3_MEM[1:0] == 2'b01) && off[0]) ||
                         ((funct3_MEM[1:0] == 2'b10) && (off != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign misalign_MEM = (state_q == IDLE) && misaligned;

    always_comb begin
        state_d   = state_q;
        stall_MEM = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (kind_ok && !misaligned) begin
                    stall_MEM = 1'b1;
                    launch    = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                stall_MEM = 1'b1;
                if (dmem_gnt) begin
                    state_d = we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                stall_MEM = 1'b1;
                if (dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            // Request is high exactly while the FSM sits in REQ.
            req_q   <= (state_d == REQ);
            if (launch) begin
                we_q <= is_store;
            end
            if (capture) begin
                rdata_q <= load_extract(funct3_q, off_q, dmem_rdata);
            end
        end
    end

    // Bus payload is latched at launch so it stays stable through REQ.
    always_ff @(posedge clk) begin
        if (launch) begin
            addr_q   <= {ALUResult_MEM[31:2], 2'b00};
            wstrb_q  <= is_store ? store_strb(funct3_MEM, off) : 4'b0000;
            wdata_q  <= store_data(funct3_MEM, storeOut_MEM);
            funct3_q <= funct3_MEM;
            off_q    <= off;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wstrb   = wstrb_q;
    assign dmem_wdata   = wdata_q;
    assign readData_MEM = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWrite_MEM;
    logic [1:0]  resultSrc_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] storeOut_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_MEM;
    logic [31:0] readData_MEM;
    logic        misalign_MEM;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd_model;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .memWrite_MEM (memWrite_MEM),
        .resultSrc_MEM(resultSrc_MEM),
        .funct3_MEM   (funct3_MEM),
        .ALUResult_MEM(ALUResult_MEM),
        .storeOut_MEM (storeOut_MEM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .stall_MEM    (stall_MEM),
        .readData_MEM (readData_MEM),
        .misalign_MEM (misalign_MEM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: arithmetic view of lanes and extension.
    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] o);
        if (f3[1:0] == 2'd0) return 4'(1 << o);
        if (f3[1:0] == 2'd1) return 4'(3 << (o & 2'd2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
        int unsigned sh;
        logic [31:0] v;
        sh = (f3[1:0] == 2'd0) ? 8 * o : (f3[1:0] == 2'd1) ? 8 * (o & 2'd2) : 0;
        v  = w >> sh;
        case (f3)
            3'd0:    return (v[7] ? 32'hFFFFFF00 : 32'h0) | (v & 32'hFF);
            3'd1:    return (v[15] ? 32'hFFFF0000 : 32'h0) | (v & 32'hFFFF);
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic drop_inputs();
        memWrite_MEM  = 1'b0;
        resultSrc_MEM = 2'b00;
    endtask

    // One complete pipeline access, checked cycle by cycle against the model.
    task automatic run_access(input string tag, input logic st, input logic [1:0] rs,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input int gdly, input int rdly,
                              input logic [31:0] rword);
        logic is_st, is_ld, kind_ok, mis, go;
        logic [1:0] o;
        is_st   = st;
        is_ld   = !st && (rs == 2'b01);
        o       = addr[1:0];
        kind_ok = (is_st && (f3 inside {3'd0, 3'd1, 3'd2})) ||
                  (is_ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
        mis     = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis = kind_ok && (((f3[1:0] == 2'd1) && o[0]) || ((f3[1:0] == 2'd2) && (o != 2'd0)));
`endif
        go = kind_ok && !mis;

        @(negedge clk);
        memWrite_MEM  = st;
        resultSrc_MEM = rs;
        funct3_MEM    = f3;
        ALUResult_MEM = addr;
        storeOut_MEM  = data;
        #1;
        chk({tag, ".idle_stall"}, {31'd0, stall_MEM}, {31'd0, go});
        chk({tag, ".misalign"}, {31'd0, misalign_MEM}, {31'd0, mis});
        chk({tag, ".idle_req"}, {31'd0, dmem_req}, 32'd0);
        if (!go) begin
            @(negedge clk);
            #1;
            chk({tag, ".noop_stall"}, {31'd0, stall_MEM}, 32'd0);
            chk({tag, ".noop_req"}, {31'd0, dmem_req}, 32'd0);
            chk({tag, ".noop_rd"}, readData_MEM, rd_model);
            drop_inputs();
            return;
        end

        @(negedge clk);
        for (int i = 0; i <= gdly; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
            chk({tag, ".req_stall"}, {31'd0, stall_MEM}, 32'd1);
            chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, is_st});
            chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
            if (is_st) begin
                chk({tag, ".wstrb"}, {28'd0, dmem_wstrb}, {28'd0, m_strb(f3, o)});
                chk({tag, ".wdata"}, dmem_wdata, m_wdata(f3, data));
            end
            if (i == gdly) dmem_gnt = 1'b1;
        end
        @(negedge clk);
        dmem_gnt = 1'b0;

        if (is_ld) begin
            for (int j = 0; j <= rdly; j++) begin
                if (j > 0) @(negedge clk);
                #1;
                chk({tag, ".wait_req"}, {31'd0, dmem_req}, 32'd0);
                chk({tag, ".wait_stall"}, {31'd0, stall_MEM}, 32'd1);
                if (j == rdly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rword;
                end
            end
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            rd_model    = m_load(f3, o, rword);
        end

        #1;
        chk({tag, ".done_stall"}, {31'd0, stall_MEM}, 32'd0);
        chk({tag, ".done_req"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, ".done_rd"}, readData_MEM, rd_model);
        drop_inputs();
        @(negedge clk);
        #1;
        chk({tag, ".back_idle"}, {31'd0, stall_MEM}, 32'd0);
        chk({tag, ".hold_rd"}, readData_MEM, rd_model);
    endtask

    initial begin
        rst           = 1'b1;
        memWrite_MEM  = 1'b0;
        resultSrc_MEM = 2'b00;
        funct3_MEM    = 3'd0;
        ALUResult_MEM = 32'd0;
        storeOut_MEM  = 32'd0;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'd0;
        rd_model      = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", {31'd0, dmem_req}, 32'd0);
        chk("rst.we", {31'd0, dmem_we}, 32'd0);
        chk("rst.rd", readData_MEM, 32'd0);
        chk("rst.stall", {31'd0, stall_MEM}, 32'd0);
        rst = 1'b0;

        // Directed cases
        run_access("sw104", 1'b1, 2'b00, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 32'd0);
        run_access("sb103", 1'b1, 2'b00, 3'd0, 32'h103, 32'h000000A5, 0, 0, 32'd0);
        run_access("lb202", 1'b0, 2'b01, 3'd0, 32'h202, 32'd0, 0, 1, 32'h00800000);
        chk("lb202.value", readData_MEM, 32'hFFFFFF80);
        run_access("lbu202", 1'b0, 2'b01, 3'd4, 32'h202, 32'd0, 0, 1, 32'h00800000);
        chk("lbu202.value", readData_MEM, 32'h00000080);
        run_access("lh301", 1'b0, 2'b01, 3'd1, 32'h301, 32'd0, 0, 0, 32'h12348765);
        run_access("sh302", 1'b1, 2'b00, 3'd1, 32'h302, 32'h0000BEEF, 1, 0, 32'd0);
        run_access("lw_gnt5", 1'b0, 2'b01, 3'd2, 32'h400, 32'd0, 5, 2, 32'hCAFEF00D);
        run_access("noop011", 1'b0, 2'b01, 3'd3, 32'h500, 32'd0, 0, 0, 32'd0);
        run_access("noop_sbu", 1'b1, 2'b01, 3'd4, 32'h504, 32'h11, 0, 0, 32'd0);
        run_access("noop_none", 1'b0, 2'b10, 3'd2, 32'h508, 32'h22, 0, 0, 32'd0);

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        memWrite_MEM  = 1'b0;
        resultSrc_MEM = 2'b01;
        funct3_MEM    = 3'd2;
        ALUResult_MEM = 32'h600;
        @(negedge clk);
        #1;
        chk("rstw.req", {31'd0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("rstw.wait_stall", {31'd0, stall_MEM}, 32'd1);
        rst = 1'b1;
        drop_inputs();
        @(negedge clk);
        rst = 1'b0;
        rd_model = 32'd0;
        #1;
        chk("rstw.stall", {31'd0, stall_MEM}, 32'd0);
        chk("rstw.req0", {31'd0, dmem_req}, 32'd0);
        chk("rstw.rd0", readData_MEM, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("rstw.late_rd", readData_MEM, 32'd0);
        chk("rstw.late_stall", {31'd0, stall_MEM}, 32'd0);

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            logic        st;
            logic [1:0]  rs;
            st = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            run_access($sformatf("rnd%0d", k), st, rs, 3'($urandom_range(0, 7)), $urandom,
                       $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, synchronous, active-high
  memWrite_MEM  in  1  store request from EX/MEM register
  resultSrc_MEM  in  2  2'b01 = load
  funct3_MEM  in  3  access size/sign
  ALUResult_MEM  in  32  byte address
  storeOut_MEM  in  32  store data, low-aligned
  dmem_req  out  1  bus request, registered
  dmem_we  out  1  1 = write
  dmem_addr  out  32  word address, {ALUResult_MEM[31:2],2'b00}
  dmem_wstrb  out  4  byte enables
  dmem_wdata  out  32  lane-replicated write data
  dmem_gnt  in  1  bus accepted request this cycle
  dmem_rvalid  in  1  read data valid
  dmem_rdata  in  32  read word
  stall_MEM  out  1  hold IF..MEM stages
  readData_MEM  out  32  extended load result
  misalign_MEM  out  1  misaligned access flag
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-003 SHALL treat access as store if memWrite_MEM=1, else load if resultSrc_MEM=2'b01; store wins if both asserted.
REQ-004 SHALL treat funct3 011/110/111, and funct3 100/101 on a store, as no-op: no request, no stall.
REQ-005 SHALL implement FSM IDLE, REQ, WAIT_R, DONE.
REQ-006 IDLE: valid aligned access -> stall_MEM=1 combinationally, next state REQ; otherwise stay, stall_MEM=0.
REQ-007 REQ: dmem_req=1, dmem_we/addr/wstrb/wdata stable; on dmem_gnt store -> DONE, load -> WAIT_R.
REQ-008 WAIT_R: dmem_req=0; dmem_rvalid is honoured no earlier than cycle after gnt; on rvalid capture extended data into readData_MEM -> DONE.
REQ-009 DONE: stall_MEM=0 one cycle, readData_MEM valid, next state IDLE.
REQ-010 stall_MEM SHALL be 1 in REQ and WAIT_R; minimum store latency 3 cycles, load 4 cycles (IDLE..DONE).
REQ-011 Store lanes: SB wstrb=1<<addr[1:0], wdata=byte x4; SH wstrb=addr[1]?1100:0011, wdata=half x2; SW wstrb=1111.
REQ-012 Load extract: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-013 readData_MEM SHALL hold its value until next load capture.
REQ-014 SHALL rely on pipeline inputs holding stable while stall_MEM=1.

Reset
REQ-015 rst SHALL force state IDLE, dmem_req=0, dmem_we=0, readData_MEM=0, stall_MEM=0 on next edge.
REQ-016 rst mid-transaction SHALL abandon access; later dmem_rvalid/dmem_gnt ignored until new REQ.

Configuration
REQ-017 Macro MEM_ACCESS_MISALIGN_TRAP_EN SHALL gate misalignment checking.
REQ-018 Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, -> misalign_MEM=1 in IDLE, no request, no stall, store suppressed, readData_MEM unchanged.
REQ-019 Undefined: misalign_MEM tied 0; offending low address bits ignored (half uses addr[1], word uses word address).

Verification
REQ-020 SW addr 0x104 data 0xDEADBEEF, gnt at first REQ cycle -> dmem_req 1 cycle, we=1, wstrb=1111, stall 2 cycles.
REQ-021 SB addr 0x103 data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, addr=0x100.
REQ-022 LB addr 0x202, rdata 0x00800000 two cycles after gnt -> readData_MEM=0xFFFFFF80; LBU same -> 0x00000080.
REQ-023 LH addr 0x301 with macro -> misalign_MEM=1, dmem_req stays 0, stall 0; without macro -> half addr[1]=0 read.
REQ-024 Load, gnt withheld 5 cycles -> dmem_req and stall held 1 all 5 cycles; rst in WAIT_R -> IDLE, late rvalid ignored.
